// File: rtl/data_memory_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and a DMA/loader port.
// CPU has priority; a saturating wait counter forces DMA grants, and a burst limit forces a CPU yield.
module data_memory_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_burst,
  input  logic [31:0] dma_a,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic [31:0] rd,
  output logic [31:0] data_memory_a,
  output logic        data_memory_we,
  output logic [31:0] data_memory_wd,
  input  logic [31:0] data_memory_rd
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {ARB, BURST, YIELD} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          cpu_gnt, dma_g, forced, arb_dma;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    if (dma_req && !dma_g)
      wait_nxt = forced ? wait_cnt : wait_cnt + WW'(1);
    else
      wait_nxt = '0;
    case (state)
      ARB: if (dma_g && dma_burst) begin
        state_nxt = BURST;
        burst_nxt = BW'(1);
      end
      BURST: begin
        if (dma_g) begin
          burst_nxt = burst_cnt + BW'(1);
          if (!dma_burst)                                state_nxt = ARB;
          else if (burst_cnt + BW'(1) == BW'(BURST_MAX)) state_nxt = YIELD;
        end else begin
          // DMA dropped its request, which unlocks the port
          state_nxt = ARB;
          burst_nxt = '0;
        end
      end
      YIELD: begin
        state_nxt = ARB;
        burst_nxt = '0;
      end
      default: begin
        state_nxt = ARB;
        burst_nxt = '0;
      end
    endcase
  end

  // Grants are combinational and forced to zero while reset is held, so no write lands in a reset cycle.
  always_comb begin
    forced  = (wait_cnt == WW'(MAX_WAIT));
    arb_dma = dma_req & (forced | ~cpu_req);
    dma_g   = 1'b0;
    if (rst) begin
      case (state)
        ARB:     dma_g = arb_dma;
        BURST:   dma_g = dma_req | arb_dma;
        YIELD:   dma_g = dma_req & ~cpu_req;
        default: dma_g = 1'b0;
      endcase
    end
    cpu_gnt   = rst & cpu_req & ~dma_g;
    cpu_stall = rst & cpu_req & ~cpu_gnt;
    dma_gnt   = dma_g;
    rd        = data_memory_rd;
    if (dma_g) begin
      data_memory_a  = dma_a;
      data_memory_wd = dma_wd;
      data_memory_we = dma_we;
    end else if (cpu_gnt) begin
      data_memory_a  = cpu_a;
      data_memory_wd = cpu_wd;
      data_memory_we = cpu_we;
    end else begin
      data_memory_a  = '0;
      data_memory_wd = '0;
      data_memory_we = 1'b0;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural data_memory
// (combinational read, write on the rising edge).
module tb_data_memory_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_a, cpu_wd;
  logic        dma_req, dma_we, dma_burst, dma_gnt;
  logic [31:0] dma_a, dma_wd;
  logic [31:0] rd, data_memory_a, data_memory_wd, data_memory_rd;
  logic        data_memory_we;
  logic [31:0] mem [0:1023];
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_burst(dma_burst), .dma_a(dma_a), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .rd(rd),
    .data_memory_a(data_memory_a), .data_memory_we(data_memory_we),
    .data_memory_wd(data_memory_wd), .data_memory_rd(data_memory_rd)
  );

  assign data_memory_rd = mem[data_memory_a[11:2]];
  always @(posedge clk) if (data_memory_we) mem[data_memory_a[11:2]] <= data_memory_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0; dma_burst = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    cpu_a = 0; cpu_wd = 0; dma_a = 0; dma_wd = 0;
    // requests present while in reset must not leak through
    rst = 0; cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1; dma_burst = 1;
    cpu_a = 32'h30; dma_a = 32'h34; cpu_wd = 32'h55; dma_wd = 32'h66;
    #2;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_dgnt", dma_gnt, 0);
    chk("rst_we", data_memory_we, 0);
    chk("rst_a", data_memory_a, 0);
    chk("rst_wd", data_memory_wd, 0);
    step; step;
    idle; #1; rst = 1;
    step;

    // CPU-only store then load
    cpu_req = 1; cpu_we = 1; cpu_a = 32'h10; cpu_wd = 32'hDEADBEEF; #1;
    chk("cpu_wr_stall", cpu_stall, 0);
    chk("cpu_wr_we", data_memory_we, 1);
    chk("cpu_wr_a", data_memory_a, 32'h10);
    chk("cpu_wr_wd", data_memory_wd, 32'hDEADBEEF);
    step;
    cpu_we = 0; #1;
    chk("cpu_rd", rd, 32'hDEADBEEF);
    chk("cpu_rd_we", data_memory_we, 0);
    step;

    // no requests
    idle;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idle_dgnt", dma_gnt, 0);
      chk("idle_we", data_memory_we, 0);
      chk("idle_a", data_memory_a, 0);
      chk("idle_wait", 32'(dut.wait_cnt), 0);
      chk("idle_burst", 32'(dut.burst_cnt), 0);
      step;
    end

    // contention: CPU wins 4 cycles, wait counter forces DMA on the 5th
    cpu_req = 1; cpu_we = 0; cpu_a = 32'h20;
    dma_req = 1; dma_we = 1; dma_burst = 0; dma_a = 32'h40;
    for (int c = 0; c < 6; c++) begin
      dma_wd = 32'h11110000 + c; #1;
      chk($sformatf("cont_dgnt%0d", c), dma_gnt, (c == 4));
      chk($sformatf("cont_stall%0d", c), cpu_stall, (c == 4));
      chk($sformatf("cont_we%0d", c), data_memory_we, (c == 4));
      chk($sformatf("cont_a%0d", c), data_memory_a, (c == 4) ? 32'h40 : 32'h20);
      step;
    end
    chk("cont_mem", mem[32'h40 >> 2], 32'h11110004);
    idle; step;

    // full burst: 8 locked beats, CPU joins on beat 2, then a yield cycle
    dma_req = 1; dma_we = 1; dma_burst = 1;
    for (int b = 0; b < 8; b++) begin
      dma_a = 32'h100 + 4 * b; dma_wd = 32'hA000 + b;
      if (b == 2) begin cpu_req = 1; cpu_we = 0; cpu_a = 32'h10; end
      #1;
      chk($sformatf("bst_dgnt%0d", b), dma_gnt, 1);
      chk($sformatf("bst_stall%0d", b), cpu_stall, (b >= 2));
      step;
    end
    dma_a = 32'h120; dma_wd = 32'hBEEF; #1;
    chk("yld_dgnt", dma_gnt, 0);
    chk("yld_stall", cpu_stall, 0);
    chk("yld_a", data_memory_a, 32'h10);
    chk("yld_rd", rd, 32'hDEADBEEF);
    step;
    cpu_req = 0; dma_burst = 0; #1;
    chk("resume_dgnt", dma_gnt, 1);
    step;
    idle; step;
    for (int b = 0; b < 8; b++) chk($sformatf("bst_mem%0d", b), mem[(32'h100 >> 2) + b], 32'hA000 + b);
    chk("resume_mem", mem[32'h120 >> 2], 32'hBEEF);

    // burst released early on beat 3; waiting CPU granted next cycle
    dma_req = 1; dma_we = 0; dma_burst = 1; dma_a = 32'h100;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin cpu_req = 1; cpu_a = 32'h10; end
      if (b == 3) dma_burst = 0;
      #1;
      chk($sformatf("early_dgnt%0d", b), dma_gnt, 1);
      step;
    end
    #1;
    chk("early_state", 32'(dut.state), 0);
    chk("early_dgnt", dma_gnt, 0);
    chk("early_stall", cpu_stall, 0);
    chk("early_a", data_memory_a, 32'h10);
    step;
    idle; step;

    // async reset mid-burst
    dma_req = 1; dma_we = 1; dma_burst = 1;
    for (int b = 0; b < 2; b++) begin
      dma_a = 32'h200 + 4 * b; dma_wd = 32'hC000 + b; step;
    end
    dma_a = 32'h208; dma_wd = 32'hBAD; cpu_req = 1; #1;
    chk("ar_pre_dgnt", dma_gnt, 1);
    rst = 0; #1;
    chk("ar_dgnt", dma_gnt, 0);
    chk("ar_we", data_memory_we, 0);
    chk("ar_stall", cpu_stall, 0);
    step;
    idle; #1; rst = 1;
    step;
    chk("ar_mem0", mem[32'h200 >> 2], 32'hC000);
    chk("ar_mem1", mem[32'h204 >> 2], 32'hC001);
    chk("ar_mem2", mem[32'h208 >> 2], 32'h0);
    chk("ar_state", 32'(dut.state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
